// File: rtl/lcd_buf_write_arbiter.sv
// lcd_buf_write_arbiter: round-robin share of the LCD buffer write port with a built-in clear sequencer
module lcd_buf_write_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int NUM_CELLS = 32,
  parameter logic [DATA_W-1:0] BLANK = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_busy,
  input  logic              r0_valid,
  output logic              r0_ready,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_data,
  input  logic              r1_valid,
  output logic              r1_ready,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_data,
  output logic              lcd_we,
  output logic [ADDR_W-1:0] lcd_waddr,
  output logic [DATA_W-1:0] lcd_wdata,
  output logic              drop_err
);
  localparam int CNT_W = $clog2(NUM_CELLS) + 1;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ptr_q, ptr_d, we_q, we_d, drop_q, drop_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d, sel_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, sel_data;
  logic arb_en, acc, in_range;
  assign arb_en   = (state_q == IDLE) && !clr_req;
  assign r0_ready = arb_en && r0_valid && (!r1_valid || !ptr_q);
  assign r1_ready = arb_en && r1_valid && (!r0_valid || ptr_q);
  assign acc      = r0_ready || r1_ready;
  assign sel_addr = r0_ready ? r0_addr : r1_addr;
  assign sel_data = r0_ready ? r0_data : r1_data;
  assign in_range = {1'b0, sel_addr} < (ADDR_W + 1)'(NUM_CELLS);
  assign clr_busy  = (state_q == CLEAR);
  assign lcd_we    = we_q;
  assign lcd_waddr = waddr_q;
  assign lcd_wdata = wdata_q;
  assign drop_err  = drop_q;
  // Next state: the clear counter holds the next cell to blank; the first blank is issued on entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    drop_d  = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (state_q == CLEAR) begin
      if (cnt_q == CNT_W'(NUM_CELLS)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        we_d    = 1'b1;
        waddr_d = ADDR_W'(cnt_q);
        wdata_d = BLANK;
        cnt_d   = cnt_q + 1'b1;
      end
    end else if (clr_req) begin
      state_d = CLEAR;
      we_d    = 1'b1;
      waddr_d = '0;
      wdata_d = BLANK;
      cnt_d   = CNT_W'(1);
    end else if (acc) begin
      ptr_d   = r0_ready;
      we_d    = in_range;
      drop_d  = !in_range;
      waddr_d = in_range ? sel_addr : waddr_q;
      wdata_d = in_range ? sel_data : wdata_q;
    end
  end
  // State and registered write-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      we_q    <= 1'b0;
      drop_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      drop_q  <= drop_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
endmodule

// File: tb/tb_lcd_buf_write_arbiter.sv
// tb_lcd_buf_write_arbiter: directed self-checking bench for lcd_buf_write_arbiter
module tb_lcd_buf_write_arbiter;
  logic clk = 1'b0;
  logic rst_n, clr_req, clr_busy;
  logic r0_valid, r0_ready, r1_valid, r1_ready;
  logic [5:0] r0_addr, r1_addr, lcd_waddr;
  logic [7:0] r0_data, r1_data, lcd_wdata;
  logic lcd_we, drop_err;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  lcd_buf_write_arbiter dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_busy(clr_busy),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_addr(r0_addr), .r0_data(r0_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_addr(r1_addr), .r1_data(r1_data),
    .lcd_we(lcd_we), .lcd_waddr(lcd_waddr), .lcd_wdata(lcd_wdata), .drop_err(drop_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; clr_req = 1'b0;
    r0_valid = 1'b0; r0_addr = '0; r0_data = '0;
    r1_valid = 1'b0; r1_addr = '0; r1_data = '0;
    @(negedge clk);
    chk("rst_we", lcd_we, 0);
    chk("rst_waddr", lcd_waddr, 0);
    chk("rst_wdata", lcd_wdata, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_drop", drop_err, 0);
    rst_n = 1'b1;
    // single write from r0
    r0_valid = 1'b1; r0_addr = 6'h00; r0_data = 8'h4C;
    #1 chk("t1_r0_ready", r0_ready, 1);
    chk("t1_r1_ready", r1_ready, 0);
    @(negedge clk);
    r0_valid = 1'b0;
    chk("t1_we", lcd_we, 1);
    chk("t1_waddr", lcd_waddr, 6'h00);
    chk("t1_wdata", lcd_wdata, 8'h4C);
    @(negedge clk);
    chk("t1_we_off", lcd_we, 0);
    chk("t1_wdata_hold", lcd_wdata, 8'h4C);
    // alternating grants with both requesters valid
    do_reset();
    r0_valid = 1'b1; r0_addr = 6'h01; r0_data = 8'h41;
    r1_valid = 1'b1; r1_addr = 6'h11; r1_data = 8'h42;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_r0_ready", r0_ready, (i % 2 == 0) ? 1 : 0);
      chk("t2_r1_ready", r1_ready, (i % 2 == 0) ? 0 : 1);
      @(negedge clk);
      chk("t2_we", lcd_we, 1);
      chk("t2_waddr", lcd_waddr, (i % 2 == 0) ? 6'h01 : 6'h11);
      chk("t2_wdata", lcd_wdata, (i % 2 == 0) ? 8'h41 : 8'h42);
    end
    #1 chk("t2_ptr_r0", r0_ready, 1);
    chk("t2_ptr_r1", r1_ready, 0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    chk("t2_we_off", lcd_we, 0);
    // clear sequence with r1 waiting
    r1_valid = 1'b1; r1_addr = 6'h05; r1_data = 8'h5A; clr_req = 1'b1;
    #1 chk("t3_r1_blocked0", r1_ready, 0);
    chk("t3_r0_blocked0", r0_ready, 0);
    @(negedge clk);
    clr_req = 1'b0;
    for (int k = 0; k < 32; k++) begin
      chk("t3_busy", clr_busy, 1);
      chk("t3_we", lcd_we, 1);
      chk("t3_waddr", lcd_waddr, k);
      chk("t3_wdata", lcd_wdata, 8'h20);
      chk("t3_r1_blocked", r1_ready, 0);
      @(negedge clk);
    end
    chk("t3_busy_fall", clr_busy, 0);
    chk("t3_we_off", lcd_we, 0);
    chk("t3_r1_ready", r1_ready, 1);
    @(negedge clk);
    r1_valid = 1'b0;
    chk("t3_r1_we", lcd_we, 1);
    chk("t3_r1_waddr", lcd_waddr, 6'h05);
    chk("t3_r1_wdata", lcd_wdata, 8'h5A);
    // out-of-range writes drop and still rotate the pointer
    r1_valid = 1'b1; r1_addr = 6'h25; r1_data = 8'h41;
    #1 chk("t4_r1_ready", r1_ready, 1);
    @(negedge clk);
    r1_valid = 1'b0;
    chk("t4_drop_we", lcd_we, 0);
    chk("t4_drop", drop_err, 1);
    chk("t4_waddr_hold", lcd_waddr, 6'h05);
    chk("t4_wdata_hold", lcd_wdata, 8'h5A);
    r0_valid = 1'b1; r0_addr = 6'h02; r0_data = 8'h61;
    r1_valid = 1'b1; r1_addr = 6'h03; r1_data = 8'h62;
    #1 chk("t4_grant_r0", r0_ready, 1);
    chk("t4_hold_r1", r1_ready, 0);
    @(negedge clk);
    r0_valid = 1'b0;
    chk("t4_drop_fall", drop_err, 0);
    chk("t4_r0_we", lcd_we, 1);
    chk("t4_r0_waddr", lcd_waddr, 6'h02);
    #1 chk("t4_r1_held_ready", r1_ready, 1);
    @(negedge clk);
    r1_valid = 1'b0;
    chk("t4_r1_waddr", lcd_waddr, 6'h03);
    chk("t4_r1_wdata", lcd_wdata, 8'h62);
    r0_valid = 1'b1; r0_addr = 6'h20; r0_data = 8'h63;
    #1 chk("t4_r0_oor_ready", r0_ready, 1);
    @(negedge clk);
    r0_valid = 1'b0;
    chk("t4_r0_drop", drop_err, 1);
    chk("t4_r0_drop_we", lcd_we, 0);
    chk("t4_r0_drop_waddr", lcd_waddr, 6'h03);
    r0_valid = 1'b1; r0_addr = 6'h02; r1_valid = 1'b1; r1_addr = 6'h03;
    #1 chk("t4_ptr_r1", r1_ready, 1);
    chk("t4_ptr_r0", r0_ready, 0);
    r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    chk("t4_idle_we", lcd_we, 0);
    // reset in the middle of a clear
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_k10", lcd_waddr, 10);
    #2 rst_n = 1'b0;
    #1 chk("t5_we", lcd_we, 0);
    chk("t5_waddr", lcd_waddr, 0);
    chk("t5_wdata", lcd_wdata, 0);
    chk("t5_busy", clr_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t5_no_we", lcd_we, 0);
      chk("t5_no_busy", clr_busy, 0);
    end
    // clr_req held through a clear
    clr_req = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 32; k++) begin
      chk("t6_we", lcd_we, 1);
      chk("t6_waddr", lcd_waddr, k);
      @(negedge clk);
    end
    chk("t6_gap_busy", clr_busy, 0);
    chk("t6_gap_we", lcd_we, 0);
    @(negedge clk);
    clr_req = 1'b0;
    chk("t6_restart_busy", clr_busy, 1);
    chk("t6_restart_waddr", lcd_waddr, 0);
    chk("t6_restart_we", lcd_we, 1);
    repeat (31) @(negedge clk);
    chk("t6_last_waddr", lcd_waddr, 31);
    @(negedge clk);
    chk("t6_end_busy", clr_busy, 0);
    chk("t6_end_we", lcd_we, 0);
    @(negedge clk);
    chk("t6_stay_busy", clr_busy, 0);
    chk("t6_stay_we", lcd_we, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
